// File: rtl/mp3_pkg.sv
// -----------------------------------------------------------------------------
// mp3_pkg
// Shared definitions for the MP3 stream fetch block:
//   - fetch_state_e : FSM state encoding (FLUSH, STREAM, DONE)
//   - TRACKn_LEN_DEF: default word counts of the three tracks
//   - decode_track  : maps the track_sel pins to a track index 0..2
// -----------------------------------------------------------------------------
package mp3_pkg;

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } fetch_state_e;

    localparam int TRACK0_LEN_DEF = 125000;
    localparam int TRACK1_LEN_DEF = 100000;
    localparam int TRACK2_LEN_DEF = 90000;

    // The pin encoding is not binary: 10 is track 1 and 01 is track 2.
    function automatic logic [1:0] decode_track(input logic [1:0] sel);
        logic [1:0] trk;
        case (sel)
            2'b00:   trk = 2'd0;
            2'b10:   trk = 2'd1;
            2'b01:   trk = 2'd2;
            default: trk = 2'd0;
        endcase
        return trk;
    endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// -----------------------------------------------------------------------------
// sync_fifo_sa
// Show-ahead synchronous FIFO: head_data always presents the oldest word.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of pointers and count (wins over push/pop)
//   push, push_data   write one word
//   pop               discard the head word (caller guarantees count != 0)
//   head_data         oldest stored word
//   count             number of stored words, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo_sa #(
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage, pointers and occupancy; storage is cleared on reset so the
    // head word reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule

// File: rtl/mp3_stream_fetch.sv
// -----------------------------------------------------------------------------
// mp3_stream_fetch
// Reads 32-bit compressed-audio words from one of three track ROMs and
// streams them to the SPI driver through a show-ahead FIFO.
// Ports:
//   mp3_clk, RST           clock (also clocks the ROMs), async active-low reset
//   track_sel              00/11 track 0, 10 track 1, 01 track 2
//   restart                pulse: replay the current track from word 0
//   rom_addr               shared registered ROM word address
//   rom_data0..2           ROM outputs, one cycle after the ROM sees rom_addr
//   out_data/out_valid/out_ready  FIFO head word with valid/ready handshake
//   track_done             one-cycle pulse after the last word transfers
//   busy                   high in FLUSH and STREAM
// -----------------------------------------------------------------------------
module mp3_stream_fetch
    import mp3_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int DEPTH      = 4,
    parameter int TRACK0_LEN = TRACK0_LEN_DEF,
    parameter int TRACK1_LEN = TRACK1_LEN_DEF,
    parameter int TRACK2_LEN = TRACK2_LEN_DEF
) (
    input  logic              mp3_clk,
    input  logic              RST,
    input  logic [1:0]        track_sel,
    input  logic              restart,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data0,
    input  logic [31:0]       rom_data1,
    input  logic [31:0]       rom_data2,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              track_done,
    output logic              busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W:0] LEN0    = TRACK0_LEN[ADDR_W:0];
    localparam logic [ADDR_W:0] LEN1    = TRACK1_LEN[ADDR_W:0];
    localparam logic [ADDR_W:0] LEN2    = TRACK2_LEN[ADDR_W:0];
    localparam logic [CW:0]     DEPTH_C = DEPTH[CW:0];
    localparam logic [CW-1:0]   ONE_C   = {{(CW-1){1'b0}}, 1'b1};

    fetch_state_e      r_state, w_state_next;
    logic [1:0]        r_cur;
    logic [1:0]        w_sel;
    logic [ADDR_W:0]   r_next_addr;
    logic [ADDR_W:0]   w_len;
    logic [ADDR_W-1:0] r_rom_addr;
    // One flag per outstanding read: [0] address sits on rom_addr this cycle,
    // [1] its data sits on rom_data this cycle and is pushed at the edge.
    logic [1:0]        r_inflight;
    logic              r_track_done;
    logic              w_abort, w_issue, w_push, w_pop, w_done, w_flush;
    logic [31:0]       w_rom_data;
    logic [31:0]       w_head;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_credit;

    assign w_sel = decode_track(track_sel);

    // Length and ROM data of the currently latched track.
    always_comb begin
        w_len      = LEN0;
        w_rom_data = rom_data0;
        case (r_cur)
            2'd0: begin
                w_len      = LEN0;
                w_rom_data = rom_data0;
            end
            2'd1: begin
                w_len      = LEN1;
                w_rom_data = rom_data1;
            end
            2'd2: begin
                w_len      = LEN2;
                w_rom_data = rom_data2;
            end
            default: begin
                w_len      = LEN0;
                w_rom_data = rom_data0;
            end
        endcase
    end

    // Track change or restart beats every other action in the same cycle.
    assign w_abort  = (r_state != FLUSH) && ((w_sel != r_cur) || restart);
    // Occupancy plus reads still in the ROM pipe can never exceed DEPTH.
    assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_inflight[0]}
                                      + {{CW{1'b0}}, r_inflight[1]};
    assign w_issue  = (r_state == STREAM) && !w_abort &&
                      (r_next_addr < w_len) && (w_credit < DEPTH_C);
    assign w_push   = (r_state == STREAM) && !w_abort && r_inflight[1];
    assign w_pop    = out_valid && out_ready && !w_abort;
    assign w_done   = (r_state == STREAM) && !w_abort && (r_next_addr == w_len) &&
                      (r_inflight == 2'b00) && (w_count == ONE_C) && w_pop;
    assign w_flush  = (r_state == FLUSH);

    // FSM state register.
    always_ff @(posedge mp3_clk or negedge RST) begin
        if (!RST) begin
            r_state <= FLUSH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FLUSH: begin
                w_state_next = STREAM;
            end
            STREAM: begin
                if (w_abort) begin
                    w_state_next = FLUSH;
                end else if (w_done) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = STREAM;
                end
            end
            DONE: begin
                if (w_abort) begin
                    w_state_next = FLUSH;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = FLUSH;
            end
        endcase
    end

    // Read-issue datapath. r_cur resets to track 0; FLUSH reloads it from
    // track_sel before it is ever used.
    always_ff @(posedge mp3_clk or negedge RST) begin
        if (!RST) begin
            r_next_addr  <= '0;
            r_rom_addr   <= '0;
            r_inflight   <= 2'b00;
            r_cur        <= 2'd0;
            r_track_done <= 1'b0;
        end else begin
            r_track_done <= w_done;
            if (r_state == FLUSH) begin
                r_next_addr <= '0;
                r_rom_addr  <= '0;
                r_inflight  <= 2'b00;
                r_cur       <= w_sel;
            end else if (w_abort) begin
                // Reads already in the ROM pipe are dropped, never pushed.
                r_inflight <= 2'b00;
            end else begin
                r_inflight <= {r_inflight[0], w_issue};
                if (w_issue) begin
                    r_rom_addr  <= r_next_addr[ADDR_W-1:0];
                    r_next_addr <= r_next_addr + 1'b1;
                end
            end
        end
    end

    sync_fifo_sa #(
        .W     (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (mp3_clk),
        .rst_n     (RST),
        .flush     (w_flush),
        .push      (w_push),
        .push_data (w_rom_data),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_count)
    );

    assign rom_addr   = r_rom_addr;
    assign out_data   = w_head;
    assign out_valid  = (w_count != '0) && (r_state == STREAM);
    assign track_done = r_track_done;
    assign busy       = (r_state != DONE);

endmodule

// File: tb/tb_mp3_stream_fetch.sv
// -----------------------------------------------------------------------------
// tb_mp3_stream_fetch
// Scoreboard bench: expected words are queued when a track is started and
// compared as the DUT hands words over. Small track lengths keep runs short.
// -----------------------------------------------------------------------------
module tb_mp3_stream_fetch;

    localparam int ADDR_W = 18;
    localparam int DEPTH  = 4;
    localparam logic [31:0] BASE0 = 32'hA000_0000;
    localparam logic [31:0] BASE1 = 32'hB100_0000;
    localparam logic [31:0] BASE2 = 32'hC200_0000;

    logic              mp3_clk   = 1'b0;
    logic              RST       = 1'b0;
    logic [1:0]        track_sel = 2'b00;
    logic              restart   = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data0 = 32'd0;
    logic [31:0]       rom_data1 = 32'd0;
    logic [31:0]       rom_data2 = 32'd0;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              track_done;
    logic              busy;

    int n_checks  = 0;
    int n_errors  = 0;
    int xfer_cnt  = 0;
    int done_cnt  = 0;
    int cyc       = 0;
    int first_cyc = -1;
    int last_cyc  = 0;
    bit prev_xfer = 1'b0;
    logic [31:0] exp_q [$];

    mp3_stream_fetch #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .TRACK0_LEN (6),
        .TRACK1_LEN (5),
        .TRACK2_LEN (3)
    ) dut (
        .mp3_clk    (mp3_clk),
        .RST        (RST),
        .track_sel  (track_sel),
        .restart    (restart),
        .rom_addr   (rom_addr),
        .rom_data0  (rom_data0),
        .rom_data1  (rom_data1),
        .rom_data2  (rom_data2),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .track_done (track_done),
        .busy       (busy)
    );

    always #5 mp3_clk = ~mp3_clk;

    // Synchronous ROM models: word i of track n is BASEn + i.
    always @(posedge mp3_clk) begin
        rom_data0 <= BASE0 + {14'd0, rom_addr};
        rom_data1 <= BASE1 + {14'd0, rom_addr};
        rom_data2 <= BASE2 + {14'd0, rom_addr};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard compare on every transfer, track_done placement,
    // and FIFO occupancy bound.
    always @(negedge mp3_clk) begin
        if (RST) begin
            cyc++;
            check("fifo_bound", {31'd0, (dut.u_fifo.count <= 3'd4)}, 32'd1);
            if (track_done) begin
                done_cnt++;
                check("done_after_last", {31'd0, prev_xfer}, 32'd1);
                check("done_valid_low", {31'd0, out_valid}, 32'd0);
            end
            prev_xfer = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", out_data, 32'hFFFF_FFFF ^ out_data);
                end else begin
                    check("word", out_data, exp_q.pop_front());
                end
                xfer_cnt++;
                prev_xfer = 1'b1;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
    end

    task automatic push_track(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + i);
    endtask

    task automatic start_scoreboard(input logic [31:0] base, input int n);
        push_track(base, n);
        xfer_cnt  = 0;
        first_cyc = -1;
    endtask

    // Called at posedge+1; leaves the bench at posedge+1.
    task automatic pulse_restart;
        restart = 1'b1;
        @(posedge mp3_clk); #1;
        restart = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge mp3_clk); #1;
            n++;
        end
        check("done_count", done_cnt, target);
    endtask

    // Returns just after the negedge on which the target transfer is seen.
    task automatic wait_xfer(input int target, input int budget);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            @(negedge mp3_clk); #1;
            n++;
        end
        check("xfer_reached", xfer_cnt, target);
    endtask

    initial begin
        // Reset
        out_ready = 1'b1;
        repeat (5) @(posedge mp3_clk);
        @(negedge mp3_clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_addr", {14'd0, rom_addr}, 32'd0);
        check("rst_done", {31'd0, track_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_data", out_data, 32'd0);

        // Basic stream of track 0
        start_scoreboard(BASE0, 6);
        @(posedge mp3_clk); #1;
        RST = 1'b1;
        @(negedge mp3_clk);
        check("flush_busy", {31'd0, busy}, 32'd1);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        @(negedge mp3_clk);
        @(negedge mp3_clk);
        @(negedge mp3_clk);
        check("issue_start", {14'd0, rom_addr}, 32'd1);
        wait_done(1, 40);
        check("basic_count", xfer_cnt, 6);
        check("basic_span", last_cyc - first_cyc, 5);
        check("basic_q_empty", exp_q.size(), 0);
        @(negedge mp3_clk);
        check("done_valid", {31'd0, out_valid}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);

        // Restart in DONE
        start_scoreboard(BASE0, 6);
        @(posedge mp3_clk); #1;
        pulse_restart();
        wait_done(2, 40);
        check("restart_count", xfer_cnt, 6);
        check("restart_q_empty", exp_q.size(), 0);

        // Backpressure
        out_ready = 1'b0;
        start_scoreboard(BASE0, 6);
        @(posedge mp3_clk); #1;
        pulse_restart();
        repeat (12) @(posedge mp3_clk);
        @(negedge mp3_clk);
        check("bp_addr", {14'd0, rom_addr}, 32'd3);
        check("bp_count", {29'd0, dut.u_fifo.count}, 32'd4);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head", out_data, BASE0);
        repeat (5) @(negedge mp3_clk);
        check("bp_addr_hold", {14'd0, rom_addr}, 32'd3);
        check("bp_head_hold", out_data, BASE0);
        @(posedge mp3_clk); #1;
        out_ready = 1'b1;
        wait_done(3, 40);
        check("bp_xfer_count", xfer_cnt, 6);
        check("bp_q_empty", exp_q.size(), 0);

        // Track switch after word 2 of track 0
        start_scoreboard(BASE0, 3);
        @(posedge mp3_clk); #1;
        pulse_restart();
        wait_xfer(3, 40);
        @(posedge mp3_clk); #1;
        track_sel = 2'b10;
        out_ready = 1'b0;
        push_track(BASE1, 5);
        @(negedge mp3_clk);
        @(negedge mp3_clk);
        check("sw_flush_valid", {31'd0, out_valid}, 32'd0);
        check("sw_flush_busy", {31'd0, busy}, 32'd1);
        @(posedge mp3_clk); #1;
        out_ready = 1'b1;
        wait_done(4, 40);
        check("sw_xfer_count", xfer_cnt, 8);
        check("sw_q_empty", exp_q.size(), 0);

        // Asynchronous reset mid-stream with three words buffered
        @(posedge mp3_clk); #1;
        out_ready = 1'b0;
        track_sel = 2'b00;
        begin
            int n = 0;
            while (dut.u_fifo.count != 3'd3 && n < 40) begin
                @(negedge mp3_clk); #1;
                n++;
            end
        end
        check("mr_count_reached", {29'd0, dut.u_fifo.count}, 32'd3);
        RST = 1'b0;
        #1;
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        check("mr_addr", {14'd0, rom_addr}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd1);
        check("mr_done", {31'd0, track_done}, 32'd0);
        check("mr_data", out_data, 32'd0);
        check("mr_count", {29'd0, dut.u_fifo.count}, 32'd0);
        exp_q.delete();
        start_scoreboard(BASE0, 6);
        repeat (3) @(posedge mp3_clk);
        #1;
        RST = 1'b1;
        out_ready = 1'b1;
        wait_done(5, 40);
        check("mr_xfer_count", xfer_cnt, 6);
        check("mr_span", last_cyc - first_cyc, 5);
        check("mr_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mp3_stream_fetch.md
Name: mp3_stream_fetch

Overview:
- Upstream feeder for the MP3 decoder SPI driver.
- Reads 32-bit compressed-audio words from three per-track block ROMs and buffers them in a small show-ahead FIFO.
- Presents words over a valid/ready handshake, detects end of track by word count, and flushes and restarts cleanly on track change.
- Runs entirely in the 1 MHz mp3_clk domain.

Parameters:
ADDR_W, 18, ROM word-address width
DEPTH, 4, FIFO depth in words; power of two, at least 2
TRACK0_LEN, 125000, word count of track 0; at least 1
TRACK1_LEN, 100000, word count of track 1; at least 1
TRACK2_LEN, 90000, word count of track 2; at least 1

Ports:
mp3_clk  in  1  clock; also clocks the ROMs
RST  in  1  reset, asynchronous, active-low
track_sel  in  2  00 selects track 0, 10 selects track 1, 01 selects track 2, 11 selects track 0
restart  in  1  single-cycle pulse; replay the current track from word 0
rom_addr  out  ADDR_W  shared ROM address, registered
rom_data0  in  32  track 0 ROM output
rom_data1  in  32  track 1 ROM output
rom_data2  in  32  track 2 ROM output
out_data  out  32  FIFO head word
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts the word; transfer occurs when out_valid and out_ready are both 1
track_done  out  1  one-cycle pulse after the last word of a track transfers
busy  out  1  high in FLUSH and STREAM

Behaviour:
- Reset values: rom_addr=0, out_valid=0, out_data=0, track_done=0, busy=1, state=FLUSH, FIFO count=0, in-flight=0, current track=decode(track_sel).
- ROM latency: a word addressed by rom_addr in cycle N is sampled from rom_data[cur] at the edge ending cycle N+1. A one-bit in-flight flag tracks each outstanding read.
- States:
  - FLUSH: clear FIFO pointers and count, rom_addr=0, next_addr=0, in-flight=0; latch cur=decode(track_sel). Go to STREAM next cycle.
  - STREAM: issue a read when next_addr < LEN[cur] and count + in-flight < DEPTH. Issuing drives rom_addr=next_addr, increments next_addr, and sets in-flight. Returning data is pushed into the FIFO.
    - When next_addr = LEN[cur], count = 0, in-flight = 0 and the final word has just transferred: pulse track_done for one cycle and go to DONE.
  - DONE: out_valid=0, no reads issued, busy=0. Hold until a restart pulse or a change of decode(track_sel), then go to FLUSH.
- Track-change or restart priority: in STREAM or DONE, if decode(track_sel) differs from cur, or restart=1, go to FLUSH on the next edge. This overrides any push, pop or track_done in that cycle. Any in-flight ROM word is discarded and is never pushed.
- FIFO:
  - Show-ahead: out_data always equals the head word; out_valid = (count != 0) and state = STREAM.
  - A push and a pop in the same cycle leave count unchanged and are legal at any fill level.
  - Overflow cannot occur by construction of the issue rule; a bench assertion checks count <= DEPTH.
  - Pointers wrap modulo DEPTH.
- Throughput: with out_ready held at 1, one word per cycle is sustained after a 2-cycle initial latency (issue, then data return).
- Address arithmetic: next_addr is ADDR_W+1 bits wide so a comparison against LEN equal to 2^ADDR_W stays valid. rom_addr is next_addr truncated to ADDR_W bits.
- Asynchronous reset mid-stream: immediate return to the reset values listed above, with no partial word transferred.
- out_data is held stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package mp3_pkg holds:
  - state encoding constants FLUSH=2'd0, STREAM=2'd1, DONE=2'd2
  - the track_sel decode function
  - the default track length constants
- One sub-module, sync_fifo_sa: parameterised show-ahead FIFO with push, pop, count, and flush inputs. The top level holds only the FSM and the read-issue logic.

Test Plan:
- Reset: hold RST=0 for 5 cycles -> out_valid=0, rom_addr=0, track_done=0, busy=1. After release -> FLUSH for 1 cycle, then rom_addr=0 is issued in the following cycle.
- Basic stream: TRACK0_LEN=6, ROM0[i]=32'hA000_0000+i, out_ready=1 -> exactly words A0000000..A0000005 in order on consecutive cycles. track_done pulses once, in the cycle after A0000005 transfers. DONE follows with out_valid=0.
- Backpressure: out_ready=0 from start -> count reaches 4, rom_addr stops at 3, no further reads. Then raise out_ready -> words 0..5 arrive with none lost or duplicated.
- Track switch mid-stream: after word 2 of track 0 transfers, change track_sel to 10 -> one FLUSH cycle. The next valid word is ROM1[0]; no track-0 word appears afterwards, including the in-flight one.
- Restart in DONE: pulse restart for 1 cycle -> track replays from word 0 with identical data, followed by a second track_done pulse.
- Reset mid-stream: deassert RST while count=3 -> outputs return to reset values asynchronously. After release, streaming restarts from word 0 of the currently selected track.
